pre_i_seq: RTL

PRE_I_SEQ -- requirements
Module: pre_i_seq

---
 rtl/pre_i_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pre_i_seq.sv
// Cycle sequencer for the pre-intra dc_planar datapath: walks BLK_NUM 8x8 blocks of
// CNT_MAX+1 cycles each, stalling the intra-block counter while gradient data is late.
module pre_i_seq #(
    parameter int BLK_NUM = 64,
    parameter int CNT_MAX = 39,
    parameter int R1_LO   = 0,
    parameter int R1_HI   = 5,
    parameter int R2_LO   = 1,
    parameter int R2_HI   = 6
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       pix_valid_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [5:0] cnt_o,
    output logic [6:0] blockcnt_o,
    output logic       counterrun1_o,
    output logic       counterrun2_o
);

    localparam logic [5:0] CNT_LAST = 6'(CNT_MAX);
    localparam logic [6:0] BLK_LAST = 7'(BLK_NUM);

    if (!(R1_LO >= 0 && R1_LO <= R1_HI && R1_HI <= CNT_MAX &&
          R2_LO >= 0 && R2_LO <= R2_HI && R2_HI <= CNT_MAX &&
          CNT_MAX <= 63 && BLK_NUM >= 1 && BLK_NUM <= 127)) begin : g_param_err
        $error("pre_i_seq: illegal window or size parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [6:0] blk_q, blk_d;

    logic advance;
    logic in_r1;
    logic in_r2;
    logic run1;
    logic run2;
    logic busy;
    logic done;
    int   cnt_int;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        advance = 1'b0;
        run1    = 1'b0;
        run2    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        cnt_int = int'(cnt_q);
        in_r1   = (cnt_int >= R1_LO) && (cnt_int <= R1_HI);
        in_r2   = (cnt_int >= R2_LO) && (cnt_int <= R2_HI);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                blk_d = '0;
                if (start_i && !abort_i) begin
                    state_d = S_RUN;
                    blk_d   = 7'd1;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // Only the pixel-fetch window waits for gradient data.
                advance = !(in_r1 && !pix_valid_i);
                run1    = advance && in_r1;
                run2    = advance && in_r2;
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    blk_d   = '0;
                end else if (advance) begin
                    if (cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + 6'd1;
                    end else if (blk_q < BLK_LAST) begin
                        cnt_d = '0;
                        blk_d = blk_q + 7'd1;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = !abort_i;
                state_d = S_IDLE;
                cnt_d   = '0;
                blk_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                blk_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    assign busy_o        = busy;
    assign done_o        = done;
    assign cnt_o         = cnt_q;
    assign blockcnt_o    = blk_q;
    assign counterrun1_o = run1;
    assign counterrun2_o = run2;

endmodule
